// File: rtl/alarm_event_queue.sv
// alarm_event_queue
//   Turns each rising edge on an alarm line into one timestamped event. Events
//   wait in a pending map, are moved one per cycle into a first-word-fall-through
//   FIFO (lowest alarm index first) and are read out over a valid/ready handshake.
//
// Ports
//   clk           clock, shared with the alarm source
//   reset         asynchronous reset, active low
//   alarm_in      alarm "finished" lines, synchronous to clk
//   evt_valid     FIFO head holds an event
//   evt_ready     consumer takes the head this cycle
//   evt_id        alarm number of the head event (0 when empty)
//   evt_ts        timestamp of the head event (0 when empty)
//   pending       edges detected but not yet moved into the FIFO
//   overflow      sticky: an edge was merged into an already pending event
//   clr_overflow  clears overflow
//   irq           evt_valid | overflow
module alarm_event_queue #(
  parameter int NUM_ALARMS = 24,
  parameter int ID_WIDTH   = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_ALARMS-1:0] alarm_in,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [ID_WIDTH-1:0]   evt_id,
  output logic [TS_WIDTH-1:0]   evt_ts,
  output logic [NUM_ALARMS-1:0] pending,
  output logic                  overflow,
  input  logic                  clr_overflow,
  output logic                  irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_ALARMS-1:0] alarm_q;
  logic [NUM_ALARMS-1:0] pending_q, pending_d;
  logic [TS_WIDTH-1:0]   stamp_q [NUM_ALARMS];
  logic [TS_WIDTH-1:0]   ts_q;
  logic                  overflow_q, overflow_d;
  logic [PTR_W-1:0]      wptr_q, rptr_q;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [ID_WIDTH-1:0]   fifo_id_mem [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]   fifo_ts_mem [FIFO_DEPTH];

  logic [NUM_ALARMS-1:0] rise, keep, clr_mask;
  logic [ID_WIDTH-1:0]   push_idx;
  logic [TS_WIDTH-1:0]   push_stamp;
  logic                  do_push, do_pop, fifo_full;

  assign rise      = alarm_in & ~alarm_q;
  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign do_push   = (|pending_q) && !fifo_full;
  assign do_pop    = evt_valid && evt_ready;

  // Lowest-index pending alarm wins: scan downward so the last hit is the lowest.
  always_comb begin
    push_idx   = '0;
    push_stamp = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_idx   = ID_WIDTH'(i);
        push_stamp = stamp_q[i];
      end
    end
  end

  assign clr_mask = do_push ? (NUM_ALARMS'(1) << push_idx) : '0;
  // Pending bits that survive this cycle; a rise on one of these is a lost event.
  assign keep       = pending_q & ~clr_mask;
  assign pending_d  = keep | rise;
  assign overflow_d = (overflow_q & ~clr_overflow) | (|(rise & keep));
  assign count_d    = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_q    <= '0;
      pending_q  <= '0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      alarm_q    <= alarm_in;
      pending_q  <= pending_d;
      ts_q       <= ts_q + 1'b1;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // A stamp is captured only when its bit is not staying pending, so a merged
  // edge keeps the original time, while an edge coinciding with the push of the
  // same alarm starts a fresh event with the new time.
  for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_stamp
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stamp_q[gi] <= '0;
      end else if (rise[gi] && !keep[gi]) begin
        stamp_q[gi] <= ts_q;
      end
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_id_mem[wptr_q] <= push_idx;
      fifo_ts_mem[wptr_q] <= push_stamp;
    end
  end

  assign evt_valid = (count_q != '0);
  assign evt_id    = evt_valid ? fifo_id_mem[rptr_q] : '0;
  assign evt_ts    = evt_valid ? fifo_ts_mem[rptr_q] : '0;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign irq       = evt_valid | overflow_q;

endmodule

// File: doc/alarm_event_queue.md
Name: alarm_event_queue

Overview:
- Downstream consumer of the ATS21 24-bit alarm/timer "finished" output (data[23:0]).
- Turns each alarm pulse into exactly one timestamped event, regardless of pulse width (ATS21 holds finished for 2 cycles).
- Events are buffered in a FIFO and presented to a host/CPU-side reader over a valid/ready handshake.
- Provides a pending map, a sticky overflow flag and an irq line.

Parameters:
- NUM_ALARMS, 24, number of alarm input lines.
- ID_WIDTH, 5, event id width; must satisfy 2^ID_WIDTH >= NUM_ALARMS.
- FIFO_DEPTH, 8, event FIFO entries; must be a power of 2.
- TS_WIDTH, 16, timestamp counter width.

Ports:
- clk  in  1  single clock; same clock as ATS21.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- alarm_in  in  NUM_ALARMS  ATS21 data[] finished lines, synchronous to clk.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts head this cycle.
- evt_id  out  ID_WIDTH  alarm number of head event.
- evt_ts  out  TS_WIDTH  timestamp of head event.
- pending  out  NUM_ALARMS  detected events not yet enqueued.
- overflow  out  1  sticky: an event was coalesced (lost).
- clr_overflow  in  1  clears overflow.
- irq  out  1  evt_valid | overflow.

Behaviour:
- Reset (reset=0, async): alarm_q, pending, stamps, FIFO pointers/count, ts and overflow all go to 0. evt_valid=0, evt_id=0, evt_ts=0, irq=0.
- Reset asserted mid-operation discards all queued and pending events.
- Because alarm_q resets to 0, a line already high at the first posedge after reset release counts as a rising edge.
- ts: free-running counter, +1 every clk, wraps from 2^TS_WIDTH-1 to 0.
- Edge detect: rise[i] = alarm_in[i] & ~alarm_q[i]. alarm_q <= alarm_in every clk.
- Pending set: on rise[i] at posedge k, pending[i] <= 1 and stamp[i] <= ts value before edge k.
- Coalescing: a rise[i] while pending[i] is already 1 and not being cleared this cycle does not change the stamp, and sets overflow.
- Arbiter: each cycle, if pending != 0 and FIFO count < FIFO_DEPTH (count sampled before the edge), push {lowest-index pending i, stamp[i]} and clear pending[i]. At most one push per cycle.
- Simultaneous rise[i] and push of i in one cycle: the pushed entry carries the old stamp. pending[i] stays 1 with the new stamp (set wins), and overflow is not set.
- Latency: alarm_in rises before posedge k, giving pending at k+0, and push plus evt_valid=1 at k+1 when that alarm is lowest and the FIFO has room.
- FIFO is first-word-fall-through. evt_id/evt_ts show the head entry and are 0 when empty.
- Pop occurs when evt_valid & evt_ready.
- Push and pop in the same cycle are both performed and count is unchanged.
- When the FIFO is full, no push occurs even if a pop happens that cycle. Pending bits simply wait.
- evt_ready while empty has no effect.
- overflow: set by coalescing, cleared by clr_overflow. Set and clear in the same cycle leaves overflow = 1.
- irq is combinational from the registered evt_valid and overflow.

Test Plan:
- Reset, single pulse: release reset, ts=0; alarm_in[3] high for 2 cycles starting at cycle 10 -> one event at cycle 11: evt_id=3, evt_ts=9 (ts value before edge 10). pending[3] clears at 11; with evt_ready=1, evt_valid drops after one cycle.
- Simultaneous alarms: alarm_in bits 0, 5 and 23 rise together at cycle 20, evt_ready=0 -> FIFO order 0, 5, 23, pushed at 21, 22, 23, all carrying the same stamp.
- Full FIFO: 10 distinct alarms (ids 0..9) rise together with evt_ready=0 -> count reaches 8 and pending = 0x000300 (ids 8, 9) holds. Raising evt_ready for 1 cycle pops id 0; id 8 is pushed on the following cycle.
- Coalescing: FIFO full, alarm 9 pending, alarm 9 pulses again -> overflow=1, irq=1, stamp[9] unchanged. clr_overflow for 1 cycle -> overflow=0.
- Timestamp wrap: let ts reach 0xFFFF, pulse alarm 2 to sample ts=0xFFFF, then pulse alarm 4 two cycles later -> events read out as (2, 0xFFFF) and (4, 0x0001).
- Reset mid-operation: with 4 events queued, drive reset=0 between clock edges -> evt_valid, pending and overflow go to 0 immediately, before the next edge. After release with alarm_in[7] held high, exactly one event id=7 is produced.
